rv32i_memoryaccess: RTL and testbench

Pipeline stage directly upstream of the writeback stage. It takes the ALU result and store operand from the execute stage and runs load/store transactions on a pipelined Wishbone data bus. It aligns and sign-extends load data, then registers rd, load data, PC and decode fields for writeback. It stalls the pipeline while a bus transaction is outstanding.

---
 rtl/rv32i_memoryaccess.sv | 186 ++++++++++++++++++
 tb/tb_rv32i_memoryaccess.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_memoryaccess.sv
// Memory-access stage of the RV32I pipeline. It runs loads and stores on a pipelined
// Wishbone data bus and hands aligned results to writeback.
module rv32i_memoryaccess (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_y,
   input  logic [31:0] i_rs2,
   input  logic [2:0]  i_funct3,
   input  logic        i_opcode_load,
   input  logic        i_opcode_store,
   input  logic        i_opcode_system,
   input  logic        i_wr_rd,
   input  logic [4:0]  i_rd_addr,
   input  logic [31:0] i_rd,
   input  logic [31:0] i_pc,
   output logic [2:0]  o_funct3,
   output logic        o_opcode_load,
   output logic        o_opcode_system,
   output logic        o_wr_rd,
   output logic [4:0]  o_rd_addr,
   output logic [31:0] o_rd,
   output logic [31:0] o_pc,
   output logic [31:0] o_data_load,
   output logic        o_wb_cyc,
   output logic        o_wb_stb,
   output logic        o_wb_we,
   output logic [31:0] o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic [3:0]  o_wb_sel,
   input  logic        i_wb_ack,
   input  logic        i_wb_stall,
   input  logic [31:0] i_wb_data,
   input  logic        i_ce,
   input  logic        i_stall,
   input  logic        i_flush,
   output logic        o_ce,
   output logic        o_stall,
   output logic        o_flush
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

   state_t      state;
   logic [1:0]  addr_lo;
   logic        discard;
   logic        ce_pend;
   logic        aligned;
   logic        is_mem;
   logic        accept;
   logic        mem_accept;
   logic        done;
   logic [3:0]  sel_next;
   logic [31:0] data_next;
   logic [7:0]  lane_byte;
   logic [15:0] lane_half;
   logic [31:0] load_value;

   // Accept is resolved without o_stall to avoid a loop through the memory-op term.
   always_comb begin
      aligned = 1'b1;
      case (i_funct3[1:0])
         2'b01:   aligned = ~i_y[0];
         2'b10:   aligned = (i_y[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      is_mem     = (i_opcode_load || i_opcode_store) && aligned;
      accept     = i_ce && !i_stall && !ce_pend && (state == IDLE) && !i_flush;
      mem_accept = accept && is_mem;
      o_stall    = i_stall || (state != IDLE) || ce_pend || mem_accept;
      o_flush    = i_flush;
      done       = ((state == REQ) && !i_wb_stall && i_wb_ack) ||
                   ((state == WAIT_ACK) && i_wb_ack);
   end

   always_comb begin
      sel_next  = 4'hF;
      data_next = i_rs2;
      case (i_funct3[1:0])
         2'b00: begin
            sel_next  = 4'b0001 << i_y[1:0];
            data_next = {4{i_rs2[7:0]}};
         end
         2'b01: begin
            sel_next  = 4'b0011 << {i_y[1], 1'b0};
            data_next = {2{i_rs2[15:0]}};
         end
         default: begin
            sel_next  = 4'hF;
            data_next = i_rs2;
         end
      endcase
   end

   // Load extraction uses the registered funct3 and address low bits of the op in flight.
   always_comb begin
      lane_byte  = i_wb_data[{addr_lo, 3'b000} +: 8];
      lane_half  = addr_lo[1] ? i_wb_data[31:16] : i_wb_data[15:0];
      load_value = i_wb_data;
      case (o_funct3)
         3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
         3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
         3'b100:  load_value = {24'b0, lane_byte};
         3'b101:  load_value = {16'b0, lane_half};
         default: load_value = i_wb_data;
      endcase
   end

   // A flush seen at any point of a bus transaction suppresses its o_ce and result.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         addr_lo         <= 2'b00;
         discard         <= 1'b0;
         ce_pend         <= 1'b0;
         o_ce            <= 1'b0;
         o_funct3        <= 3'b000;
         o_opcode_load   <= 1'b0;
         o_opcode_system <= 1'b0;
         o_wr_rd         <= 1'b0;
         o_rd_addr       <= 5'd0;
         o_rd            <= 32'd0;
         o_pc            <= 32'd0;
         o_data_load     <= 32'd0;
         o_wb_cyc        <= 1'b0;
         o_wb_stb        <= 1'b0;
         o_wb_we         <= 1'b0;
         o_wb_addr       <= 32'd0;
         o_wb_data       <= 32'd0;
         o_wb_sel        <= 4'b0000;
      end else begin
         o_ce <= 1'b0;
         if (accept) begin
            o_funct3        <= i_funct3;
            o_opcode_load   <= i_opcode_load;
            o_opcode_system <= i_opcode_system;
            o_wr_rd         <= i_wr_rd;
            o_rd_addr       <= i_rd_addr;
            o_rd            <= i_rd;
            o_pc            <= i_pc;
            addr_lo         <= i_y[1:0];
            discard         <= 1'b0;
            if (is_mem) begin
               state     <= REQ;
               o_wb_cyc  <= 1'b1;
               o_wb_stb  <= 1'b1;
               o_wb_we   <= i_opcode_store;
               o_wb_addr <= {i_y[31:2], 2'b00};
               o_wb_sel  <= sel_next;
               o_wb_data <= data_next;
            end else begin
               o_ce <= 1'b1;
            end
         end
         if ((state != IDLE) && i_flush) begin
            discard <= 1'b1;
         end
         if (ce_pend) begin
            if (i_flush) begin
               ce_pend <= 1'b0;
            end else if (!i_stall) begin
               ce_pend <= 1'b0;
               o_ce    <= 1'b1;
            end
         end
         if ((state == REQ) && !i_wb_stall) begin
            o_wb_stb <= 1'b0;
            state    <= WAIT_ACK;
         end
         if (done) begin
            o_wb_cyc <= 1'b0;
            state    <= IDLE;
            if (!(discard || i_flush)) begin
               if (o_opcode_load) begin
                  o_data_load <= load_value;
               end
               if (i_stall) begin
                  ce_pend <= 1'b1;
               end else begin
                  o_ce <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rv32i_memoryaccess.sv
// Directed bench for rv32i_memoryaccess: bus signals are checked inline, retired
// instructions are matched against a scoreboard of expected writeback results.
module tb_rv32i_memoryaccess;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] i_y, i_rs2, i_rd, i_pc, i_wb_data;
   logic [2:0]  i_funct3;
   logic        i_opcode_load, i_opcode_store, i_opcode_system, i_wr_rd;
   logic [4:0]  i_rd_addr;
   logic        i_wb_ack, i_wb_stall, i_ce, i_stall, i_flush;
   logic [2:0]  o_funct3;
   logic        o_opcode_load, o_opcode_system, o_wr_rd;
   logic [4:0]  o_rd_addr;
   logic [31:0] o_rd, o_pc, o_data_load, o_wb_addr, o_wb_data;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [3:0]  o_wb_sel;
   logic        o_ce, o_stall, o_flush;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic        wr_rd;
      logic        check_load;
      logic [31:0] data_load;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int checks = 0;
   int errors = 0;

   rv32i_memoryaccess dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_y(i_y), .i_rs2(i_rs2), .i_funct3(i_funct3),
      .i_opcode_load(i_opcode_load), .i_opcode_store(i_opcode_store),
      .i_opcode_system(i_opcode_system), .i_wr_rd(i_wr_rd), .i_rd_addr(i_rd_addr),
      .i_rd(i_rd), .i_pc(i_pc), .o_funct3(o_funct3), .o_opcode_load(o_opcode_load),
      .o_opcode_system(o_opcode_system), .o_wr_rd(o_wr_rd), .o_rd_addr(o_rd_addr),
      .o_rd(o_rd), .o_pc(o_pc), .o_data_load(o_data_load), .o_wb_cyc(o_wb_cyc),
      .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data),
      .o_wb_sel(o_wb_sel), .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall),
      .i_wb_data(i_wb_data), .i_ce(i_ce), .i_stall(i_stall), .i_flush(i_flush),
      .o_ce(o_ce), .o_stall(o_stall), .o_flush(o_flush)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Drives one instruction for a single accept edge and records what writeback should see.
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] y, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [4:0] rd_addr,
                                input logic expect_ce, input logic check_load,
                                input logic [31:0] exp_load);
      exp_t x;
      i_opcode_load  = ld;
      i_opcode_store = st;
      i_funct3       = f3;
      i_y            = y;
      i_rs2          = rs2;
      i_pc           = pc;
      i_rd_addr      = rd_addr;
      i_rd           = y;
      i_wr_rd        = !st;
      i_ce           = 1'b1;
      if (expect_ce) begin
         x.pc = pc; x.rd_addr = rd_addr; x.wr_rd = !st;
         x.check_load = check_load; x.data_load = exp_load;
         sb.push_back(x);
      end
      tick();
      i_ce = 1'b0;
      i_opcode_load = 1'b0;
      i_opcode_store = 1'b0;
   endtask

   task automatic ackNow(input logic [31:0] data);
      i_wb_data = data;
      i_wb_ack  = 1'b1;
      tick();
      i_wb_ack  = 1'b0;
   endtask

   // Scoreboard side: every o_ce pulse must match the oldest outstanding instruction.
   always @(negedge i_clk) begin
      if (i_rst_n && o_ce) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_ce", {31'b0, o_ce}, 32'h0);
         end else begin
            e = sb.pop_front();
            checkOutput("wb_pc", o_pc, e.pc);
            checkOutput("wb_rd_addr", {27'b0, o_rd_addr}, {27'b0, e.rd_addr});
            checkOutput("wb_wr_rd", {31'b0, o_wr_rd}, {31'b0, e.wr_rd});
            if (e.check_load) checkOutput("wb_data_load", o_data_load, e.data_load);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout observed=running expected=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   initial begin
      i_rst_n = 1'b0; i_y = '0; i_rs2 = '0; i_rd = '0; i_pc = '0; i_wb_data = '0;
      i_funct3 = '0; i_opcode_load = 0; i_opcode_store = 0; i_opcode_system = 0;
      i_wr_rd = 0; i_rd_addr = '0; i_wb_ack = 0; i_wb_stall = 0; i_ce = 0;
      i_stall = 0; i_flush = 0;
      tick(); tick();
      checkOutput("rst_ce", {31'b0, o_ce}, 32'h0);
      checkOutput("rst_cyc", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("rst_stb", {31'b0, o_wb_stb}, 32'h0);
      checkOutput("rst_we", {31'b0, o_wb_we}, 32'h0);
      checkOutput("rst_sel", {28'b0, o_wb_sel}, 32'h0);
      checkOutput("rst_pc", o_pc, 32'h0);
      checkOutput("rst_data_load", o_data_load, 32'h0);
      i_rst_n = 1'b1;

      // SW, ack in the cycle after the request
      applyStimulus(0, 1, 3'b010, 32'h1000, 32'hDEADBEEF, 32'h100, 5'd0, 1, 0, 0);
      checkOutput("sw_cyc", {31'b0, o_wb_cyc}, 32'h1);
      checkOutput("sw_stb", {31'b0, o_wb_stb}, 32'h1);
      checkOutput("sw_we", {31'b0, o_wb_we}, 32'h1);
      checkOutput("sw_addr", o_wb_addr, 32'h1000);
      checkOutput("sw_sel", {28'b0, o_wb_sel}, 32'hF);
      checkOutput("sw_data", o_wb_data, 32'hDEADBEEF);
      checkOutput("sw_stall", {31'b0, o_stall}, 32'h1);
      ackNow(32'h0);
      checkOutput("sw_done_cyc", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("sw_done_ce", {31'b0, o_ce}, 32'h1);
      checkOutput("sw_done_stall", {31'b0, o_stall}, 32'h0);

      // LB / LBU on the top byte lane
      applyStimulus(1, 0, 3'b000, 32'h2003, 32'h0, 32'h104, 5'd5, 1, 1, 32'hFFFFFF80);
      checkOutput("lb_sel", {28'b0, o_wb_sel}, 32'h8);
      checkOutput("lb_we", {31'b0, o_wb_we}, 32'h0);
      checkOutput("lb_addr", o_wb_addr, 32'h2000);
      ackNow(32'h80FF0000);
      applyStimulus(1, 0, 3'b100, 32'h2003, 32'h0, 32'h108, 5'd6, 1, 1, 32'h00000080);
      ackNow(32'h80FF0000);

      // LHU with three stalled cycles, then ack two cycles later
      applyStimulus(1, 0, 3'b101, 32'h2002, 32'h0, 32'h10C, 5'd7, 1, 1, 32'h0000BEEF);
      checkOutput("lhu_sel", {28'b0, o_wb_sel}, 32'hC);
      i_wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checkOutput("lhu_stb_held", {31'b0, o_wb_stb}, 32'h1);
         tick();
      end
      checkOutput("lhu_stb_last", {31'b0, o_wb_stb}, 32'h1);
      i_wb_stall = 1'b0;
      tick();
      checkOutput("lhu_stb_drop", {31'b0, o_wb_stb}, 32'h0);
      checkOutput("lhu_cyc_wait", {31'b0, o_wb_cyc}, 32'h1);
      checkOutput("lhu_stall_wait", {31'b0, o_stall}, 32'h1);
      tick();
      checkOutput("lhu_stall_wait2", {31'b0, o_stall}, 32'h1);
      ackNow(32'hBEEF1234);

      // SB lane replication, then misaligned LW skipping the bus
      applyStimulus(0, 1, 3'b000, 32'h11, 32'hAB, 32'h110, 5'd0, 1, 0, 0);
      checkOutput("sb_sel", {28'b0, o_wb_sel}, 32'h2);
      checkOutput("sb_data", o_wb_data, 32'hABABABAB);
      checkOutput("sb_addr", o_wb_addr, 32'h10);
      ackNow(32'h0);
      applyStimulus(1, 0, 3'b010, 32'h102, 32'h0, 32'h114, 5'd8, 1, 0, 0);
      checkOutput("mis_cyc", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("mis_stb", {31'b0, o_wb_stb}, 32'h0);
      checkOutput("mis_ce", {31'b0, o_ce}, 32'h1);

      // Non-memory op with 1-cycle latency, then a flush blocking accept while idle
      applyStimulus(0, 0, 3'b000, 32'h55, 32'h0, 32'h118, 5'd9, 1, 0, 0);
      checkOutput("alu_ce", {31'b0, o_ce}, 32'h1);
      i_flush = 1'b1; i_ce = 1'b1; i_pc = 32'h11C;
      tick();
      i_flush = 1'b0; i_ce = 1'b0;
      checkOutput("idle_flush_ce", {31'b0, o_ce}, 32'h0);
      checkOutput("idle_flush_pc", o_pc, 32'h118);

      // Flush while waiting for ack discards the load
      applyStimulus(1, 0, 3'b010, 32'h3000, 32'h0, 32'h120, 5'd10, 0, 0, 0);
      tick();
      i_flush = 1'b1;
      #1;
      checkOutput("flush_mirror_hi", {31'b0, o_flush}, 32'h1);
      tick();
      i_flush = 1'b0;
      #1;
      checkOutput("flush_mirror_lo", {31'b0, o_flush}, 32'h0);
      checkOutput("flush_cyc_held", {31'b0, o_wb_cyc}, 32'h1);
      tick();
      ackNow(32'h12345678);
      checkOutput("flush_cyc_drop", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("flush_ce", {31'b0, o_ce}, 32'h0);

      // Downstream stall on the ack edge: data latched, o_ce deferred
      applyStimulus(1, 0, 3'b010, 32'h5000, 32'h0, 32'h124, 5'd11, 1, 1, 32'hCAFEF00D);
      i_stall = 1'b1;
      ackNow(32'hCAFEF00D);
      checkOutput("stall_ack_ce", {31'b0, o_ce}, 32'h0);
      checkOutput("stall_ack_cyc", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("stall_ack_data", o_data_load, 32'hCAFEF00D);
      tick();
      checkOutput("stall_hold_ce", {31'b0, o_ce}, 32'h0);
      i_stall = 1'b0;
      tick();
      checkOutput("stall_release_ce", {31'b0, o_ce}, 32'h1);

      // Asynchronous reset during WAIT, stray ack ignored, next access normal
      applyStimulus(1, 0, 3'b010, 32'h4000, 32'h0, 32'h128, 5'd12, 0, 0, 0);
      tick();
      checkOutput("rstw_cyc_before", {31'b0, o_wb_cyc}, 32'h1);
      i_rst_n = 1'b0;
      #1;
      checkOutput("rstw_cyc", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("rstw_stb", {31'b0, o_wb_stb}, 32'h0);
      checkOutput("rstw_ce", {31'b0, o_ce}, 32'h0);
      tick();
      i_rst_n = 1'b1;
      ackNow(32'h0);
      checkOutput("rstw_ack_cyc", {31'b0, o_wb_cyc}, 32'h0);
      checkOutput("rstw_ack_ce", {31'b0, o_ce}, 32'h0);
      applyStimulus(0, 1, 3'b001, 32'h6002, 32'h00001234, 32'h12C, 5'd0, 1, 0, 0);
      checkOutput("post_sh_cyc", {31'b0, o_wb_cyc}, 32'h1);
      checkOutput("post_sh_sel", {28'b0, o_wb_sel}, 32'hC);
      checkOutput("post_sh_data", o_wb_data, 32'h12341234);
      ackNow(32'h0);

      tick(); tick();
      checkOutput("sb_drained", sb.size(), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
